inc_strobe_gen: RTL and testbench

- Upstream stage of the increment counter (clk/test_inc/out block): turns a burst request into N clean single-cycle increment strobes.
- The counter increments on a rising edge of its strobe, so strobes are always separated by at least one low cycle. This guarantees N requested increments produce exactly N counter edges.
- Sits between the test/control sequencer and the counter's test_inc input. Reports busy, per-burst progress and completion.

---
 rtl/inc_pkg.sv | 16 +
 rtl/strobe_gap_timer.sv | 28 ++
 rtl/inc_strobe_gen.sv | 130 +++++++++++++
 tb/tb_inc_strobe_gen.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/inc_pkg.sv
// Shared definitions for the increment strobe generator: FSM states and defaults.
// The minimum gap guarantees a low cycle between strobes for downstream edge detection.
package inc_pkg;

    localparam int CNT_W_DEF = 4;
    localparam int GAP_W_DEF = 4;
    localparam int MIN_GAP   = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2,
        FIN   = 2'd3
    } state_t;

endpackage

// File: rtl/strobe_gap_timer.sv
// Loadable count-down timer measuring the low cycles between strobes.
// A load takes priority over a decrement; the count saturates at zero.
module strobe_gap_timer #(
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [GAP_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [GAP_W-1:0] cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= load_val;
        end else if (dec && (cnt_reg != '0)) begin
            cnt_reg <= cnt_reg - GAP_W'(1);
        end
    end

    assign zero = (cnt_reg == '0);

endmodule

// File: rtl/inc_strobe_gen.sv
// Turns an accepted burst request into N single-cycle increment strobes,
// each followed by at least one low cycle, and reports busy/progress/completion.
module inc_strobe_gen
    import inc_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int GAP_W = GAP_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [CNT_W-1:0] req_count,
    input  logic [GAP_W-1:0] req_gap,
    output logic             inc_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sent
);

    state_t           state_reg, state_next;
    logic             inc_reg, inc_next;
    logic             done_reg, done_next;
    logic             busy_reg, busy_next;
    logic [CNT_W-1:0] sent_reg, sent_next;
    logic [CNT_W-1:0] remaining_reg, remaining_next;
    logic [GAP_W-1:0] gap_len_reg, gap_len_next;
    logic [GAP_W-1:0] req_gap_eff;
    logic             accept;
    logic             timer_load;
    logic             timer_dec;
    logic             gap_zero;

    assign req_ready   = (state_reg == IDLE) && !rst;
    assign accept      = req_valid && req_ready;
    // A zero gap would make strobes back-to-back and merge counter edges.
    assign req_gap_eff = (req_gap < GAP_W'(MIN_GAP)) ? GAP_W'(MIN_GAP) : req_gap;

    strobe_gap_timer #(
        .GAP_W(GAP_W)
    ) u_gap_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (gap_len_reg - GAP_W'(1)),
        .dec      (timer_dec),
        .zero     (gap_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            inc_reg       <= 1'b0;
            done_reg      <= 1'b0;
            busy_reg      <= 1'b0;
            sent_reg      <= '0;
            remaining_reg <= '0;
            gap_len_reg   <= GAP_W'(MIN_GAP);
        end else begin
            state_reg     <= state_next;
            inc_reg       <= inc_next;
            done_reg      <= done_next;
            busy_reg      <= busy_next;
            sent_reg      <= sent_next;
            remaining_reg <= remaining_next;
            gap_len_reg   <= gap_len_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        inc_next       = 1'b0;
        done_next      = 1'b0;
        sent_next      = sent_reg;
        remaining_next = remaining_reg;
        gap_len_next   = gap_len_reg;
        timer_load     = 1'b0;
        timer_dec      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    gap_len_next = req_gap_eff;
                    if (req_count != '0) begin
                        state_next     = PULSE;
                        inc_next       = 1'b1;
                        sent_next      = CNT_W'(1);
                        remaining_next = req_count - CNT_W'(1);
                    end else begin
                        state_next     = FIN;
                        done_next      = 1'b1;
                        sent_next      = '0;
                        remaining_next = '0;
                    end
                end
            end
            PULSE: begin
                if (remaining_reg == '0) begin
                    state_next = FIN;
                    done_next  = 1'b1;
                end else begin
                    state_next = GAP;
                    timer_load = 1'b1;
                end
            end
            GAP: begin
                if (gap_zero) begin
                    state_next     = PULSE;
                    inc_next       = 1'b1;
                    sent_next      = sent_reg + CNT_W'(1);
                    remaining_next = remaining_reg - CNT_W'(1);
                end else begin
                    timer_dec = 1'b1;
                end
            end
            FIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        busy_next = (state_next != IDLE);
    end

    assign inc_out = inc_reg;
    assign done    = done_reg;
    assign busy    = busy_reg;
    assign sent    = sent_reg;

endmodule

// File: tb/tb_inc_strobe_gen.sv
// Bench for inc_strobe_gen: per-cycle arithmetic model of the strobe timeline,
// a table of directed bursts, hand sequences for held requests / reset, and random traffic.
module tb_inc_strobe_gen;

    localparam int CNT_W = 4;
    localparam int GAP_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req_valid = 1'b0;
    logic [CNT_W-1:0] req_count = '0;
    logic [GAP_W-1:0] req_gap = '0;
    logic             req_ready;
    logic             inc_out;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] sent;

    inc_strobe_gen #(
        .CNT_W(CNT_W),
        .GAP_W(GAP_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_count (req_count),
        .req_gap   (req_gap),
        .inc_out   (inc_out),
        .busy      (busy),
        .done      (done),
        .sent      (sent)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int edges = 0;
    bit prev_inc = 1'b0;
    bit m_ready = 1'b0;
    bit have_burst = 1'b0;
    bit just_acc = 1'b0;
    int b_start = 0;
    int b_c = 0;
    int b_g = 1;

    typedef struct {
        int count;
        int gap;
        int exp_strobes;
        int exp_done_off;
        int exp_sent;
    } vec_t;
    vec_t vecs[7];

    task automatic cmp(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
        end
    endtask

    // Expected outputs from the burst timeline: strobe k at offset k*(1+gap), done right after the last.
    task automatic check();
        int e_inc, e_done, e_busy, e_ready, e_sent, d, len, per;
        e_inc = 0; e_done = 0; e_busy = 0; e_ready = 0; e_sent = 0;
        if (rst) begin
            have_burst = 1'b0;
        end else if (!have_burst) begin
            e_ready = 1;
        end else begin
            per = b_g + 1;
            d   = cyc - b_start;
            len = (b_c == 0) ? 0 : (b_c - 1) * per + 1;
            if (d < len) begin
                e_inc  = (d % per == 0) ? 1 : 0;
                e_sent = d / per + 1;
                e_busy = 1;
            end else if (d == len) begin
                e_done = 1;
                e_busy = 1;
                e_sent = b_c;
            end else begin
                e_ready = 1;
                e_sent  = b_c;
            end
        end
        cmp("inc_out", int'(inc_out), e_inc);
        cmp("done", int'(done), e_done);
        cmp("busy", int'(busy), e_busy);
        cmp("req_ready", int'(req_ready), e_ready);
        cmp("sent", int'(sent), e_sent);
        m_ready = (e_ready != 0);
        if (inc_out && !prev_inc) edges++;
        prev_inc = inc_out;
    endtask

    task automatic tick();
        bit acc;
        int cap_c, cap_g;
        acc   = req_valid && !rst && m_ready;
        cap_c = int'(req_count);
        cap_g = int'(req_gap);
        @(posedge clk);
        #1;
        cyc++;
        just_acc = acc;
        if (acc) begin
            have_burst = 1'b1;
            b_start    = cyc;
            b_c        = cap_c;
            b_g        = (cap_g == 0) ? 1 : cap_g;
            $display("cyc=%0d accept count=%0d gap=%0d", cyc, cap_c, cap_g);
        end
        check();
    endtask

    task automatic run_burst(input int c, input int g, output int strobes,
                             output int done_off, output int sent_at_done);
        int e0, acc_cyc;
        e0 = edges; acc_cyc = -1; done_off = -1; sent_at_done = -1;
        req_valid = 1'b1;
        req_count = CNT_W'(c);
        req_gap   = GAP_W'(g);
        for (int k = 0; k < 300 && done_off < 0; k++) begin
            tick();
            if (just_acc) begin
                acc_cyc   = cyc;
                req_valid = 1'b0;
                req_count = CNT_W'($urandom_range(15, 0));
                req_gap   = GAP_W'($urandom_range(15, 0));
            end
            if (acc_cyc >= 0 && done) begin
                done_off     = cyc - acc_cyc;
                sent_at_done = int'(sent);
            end
        end
        strobes = edges - e0;
    endtask

    initial begin
        int e0, n, st, doff, sad;

        vecs[0] = '{3, 2, 3, 7, 3};
        vecs[1] = '{2, 0, 2, 3, 2};
        vecs[2] = '{0, 9, 0, 0, 0};
        vecs[3] = '{1, 5, 1, 1, 1};
        vecs[4] = '{4, 1, 4, 7, 4};
        vecs[5] = '{15, 0, 15, 29, 15};
        vecs[6] = '{15, 15, 15, 225, 15};

        // Reset held, with a request present: reset wins
        req_valid = 1'b1;
        req_count = CNT_W'(3);
        repeat (3) tick();
        req_valid = 1'b0;
        rst = 1'b0;
        #1;
        check();

        e0 = edges;
        repeat (20) tick();
        cmp("idle_no_strobes", edges - e0, 0);

        for (int i = 0; i < 7; i++) begin
            run_burst(vecs[i].count, vecs[i].gap, st, doff, sad);
            cmp("vec_strobes", st, vecs[i].exp_strobes);
            cmp("vec_done_off", doff, vecs[i].exp_done_off);
            cmp("vec_sent", sad, vecs[i].exp_sent);
            $display("vec %0d count=%0d gap=%0d strobes=%0d done_off=%0d sent=%0d",
                     i, vecs[i].count, vecs[i].gap, st, doff, sad);
        end
        repeat (2) tick();

        // Request held while busy: second burst waits for IDLE
        e0 = edges; n = 0;
        req_valid = 1'b1; req_count = CNT_W'(1); req_gap = GAP_W'(2);
        for (int k = 0; k < 100 && n < 2; k++) begin
            tick();
            if (just_acc) begin
                n++;
                req_count = CNT_W'(4);
            end
        end
        req_valid = 1'b0;
        for (int k = 0; k < 100 && !m_ready; k++) tick();
        cmp("held_accepts", n, 2);
        cmp("held_strobes", edges - e0, 5);
        cmp("held_ctr_mod4", (edges - e0) % 4, 1);

        // Reset during GAP of a count=5 burst after two strobes
        e0 = edges;
        req_valid = 1'b1; req_count = CNT_W'(5); req_gap = GAP_W'(3);
        for (int k = 0; k < 50; k++) begin
            tick();
            if (just_acc) req_valid = 1'b0;
            if (edges - e0 == 2 && !inc_out && busy) break;
        end
        cmp("pre_reset_strobes", edges - e0, 2);
        rst = 1'b1;
        req_valid = 1'b1; req_count = CNT_W'(1); req_gap = GAP_W'(0);
        #1;
        check();
        repeat (2) tick();
        rst = 1'b0;
        #1;
        check();
        e0 = edges;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (just_acc) req_valid = 1'b0;
            if (!req_valid && m_ready) break;
        end
        cmp("post_reset_strobes", edges - e0, 1);

        // Random traffic with inputs changing every cycle and occasional mid-burst reset
        for (int k = 0; k < 3000; k++) begin
            req_valid = ($urandom_range(2, 0) == 0);
            req_count = CNT_W'($urandom_range(15, 0));
            req_gap   = ($urandom_range(9, 0) == 0) ? GAP_W'(15) : GAP_W'($urandom_range(4, 0));
            if ($urandom_range(299, 0) == 0) begin
                rst = 1'b1;
                #1;
                check();
                tick();
                rst = 1'b0;
                #1;
                check();
            end else begin
                tick();
            end
        end
        req_valid = 1'b0;
        for (int k = 0; k < 300 && !m_ready; k++) tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
